// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, load extraction, writeback select and retire counter.
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [4:0]       rd_in,
    input  logic             regwrite_in,
    input  logic [1:0]       wb_sel,
    input  logic [2:0]       funct3,
    input  logic [1:0]       addr_lo,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      mem_rdata,
    input  logic [31:0]      pc_plus4,
    output logic [4:0]       rd,
    output logic [31:0]      wd,
    output logic             regwrite,
    output logic             load_misalign,
    output logic [CNT_W-1:0] retire_count
);
    logic        v, regwrite_q, misalign_q;
    logic [4:0]  rd_q;
    logic [1:0]  wb_sel_q, addr_lo_q;
    logic [2:0]  funct3_q;
    logic [31:0] alu_q, mem_q, pc4_q, load;
    logic [7:0]  b;
    logic [15:0] h;

    always_ff @(posedge clk) begin
        if (rst) begin
            v            <= 1'b0;
            rd_q         <= '0;
            regwrite_q   <= 1'b0;
            wb_sel_q     <= '0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            alu_q        <= '0;
            mem_q        <= '0;
            pc4_q        <= '0;
            retire_count <= '0;
        end else if (flush) begin
            v <= 1'b0;
        end else if (!stall) begin
            v            <= in_valid;
            rd_q         <= rd_in;
            regwrite_q   <= regwrite_in;
            wb_sel_q     <= wb_sel;
            funct3_q     <= funct3;
            addr_lo_q    <= addr_lo;
            alu_q        <= alu_result;
            mem_q        <= mem_rdata;
            pc4_q        <= pc_plus4;
            retire_count <= retire_count + CNT_W'(v);
        end
    end

    // funct3[1:0]: 00 byte, 01 half, else word; funct3[2] selects zero-extension
    always_comb begin
        b          = mem_q[{addr_lo_q, 3'b000} +: 8];
        h          = addr_lo_q[1] ? mem_q[31:16] : mem_q[15:0];
        load       = funct3_q[1:0] == 2'b00 ? {{24{b[7] & ~funct3_q[2]}}, b} :
                     funct3_q[1:0] == 2'b01 ? {{16{h[15] & ~funct3_q[2]}}, h} : mem_q;
        misalign_q = wb_sel_q == 2'b01 &&
                     (funct3_q[1:0] == 2'b01 ? addr_lo_q[0] :
                      funct3_q[1:0] != 2'b00 && addr_lo_q != 2'b00);
        wd         = wb_sel_q == 2'b00 ? alu_q :
                     wb_sel_q == 2'b01 ? load  :
                     wb_sel_q == 2'b10 ? pc4_q : 32'h0;
    end

    assign rd            = rd_q;
    assign regwrite      = v & regwrite_q & (rd_q != 5'd0) & ~misalign_q & ~stall;
    assign load_misalign = v & misalign_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors for wb_stage with a register-file model on the write port.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush, regwrite_in;
    logic [4:0]  rd_in;
    logic [1:0]  wb_sel, addr_lo;
    logic [2:0]  funct3;
    logic [31:0] alu_result, mem_rdata, pc_plus4;
    logic [4:0]  rd, rd4;
    logic [31:0] wd, wd4;
    logic        regwrite, regwrite4, load_misalign, load_misalign4;
    logic [31:0] retire_count;
    logic [3:0]  retire_count4;
    logic [31:0] rf [32];
    int          w7;
    int          vectors = 0, errs = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rd_in(rd_in), .regwrite_in(regwrite_in), .wb_sel(wb_sel), .funct3(funct3),
        .addr_lo(addr_lo), .alu_result(alu_result), .mem_rdata(mem_rdata),
        .pc_plus4(pc_plus4), .rd(rd), .wd(wd), .regwrite(regwrite),
        .load_misalign(load_misalign), .retire_count(retire_count)
    );

    wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rd_in(rd_in), .regwrite_in(regwrite_in), .wb_sel(wb_sel), .funct3(funct3),
        .addr_lo(addr_lo), .alu_result(alu_result), .mem_rdata(mem_rdata),
        .pc_plus4(pc_plus4), .rd(rd4), .wd(wd4), .regwrite(regwrite4),
        .load_misalign(load_misalign4), .retire_count(retire_count4)
    );

    // register file records every enabled write, x0 included, so a stray x0 write is visible
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
            w7 <= 0;
        end else if (regwrite) begin
            rf[rd] <= wd;
            if (rd == 5'd7) w7 <= w7 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] r, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [1:0] a, input logic [31:0] alu, input logic [31:0] mem);
        rd_in = r; regwrite_in = 1'b1; wb_sel = sel; funct3 = f3; addr_lo = a;
        alu_result = alu; mem_rdata = mem; pc_plus4 = 32'h0000_1004;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; regwrite_in = 1'b0;
        rd_in = '0; wb_sel = '0; funct3 = '0; addr_lo = '0;
        alu_result = '0; mem_rdata = '0; pc_plus4 = '0;
        tick; tick;
        rst = 1'b0;
        chk("rst_regwrite", 32'(regwrite), 32'h0);
        chk("rst_count", retire_count, 32'h0);

        issue(5'd6, 2'b00, 3'b000, 2'd0, 32'hA456_2D47, 32'h0);
        chk("alu_rd", 32'(rd), 32'd6);
        chk("alu_wd", wd, 32'hA456_2D47);
        chk("alu_regwrite", 32'(regwrite), 32'h1);
        chk("alu_count_pre", retire_count, 32'h0);
        tick;
        chk("alu_one_cycle", 32'(regwrite), 32'h0);
        chk("alu_x6", rf[6], 32'hA456_2D47);
        chk("alu_count", retire_count, 32'd1);

        issue(5'd10, 2'b01, 3'b000, 2'd3, 32'h0, 32'hDEAD_BEEF);
        chk("lb3", wd, 32'hFFFF_FFDE);
        issue(5'd10, 2'b01, 3'b100, 2'd0, 32'h0, 32'hDEAD_BEEF);
        chk("lbu0", wd, 32'h0000_00EF);
        issue(5'd10, 2'b01, 3'b001, 2'd2, 32'h0, 32'hDEAD_BEEF);
        chk("lh2", wd, 32'hFFFF_DEAD);
        issue(5'd10, 2'b01, 3'b101, 2'd0, 32'h0, 32'hDEAD_BEEF);
        chk("lhu0", wd, 32'h0000_BEEF);
        issue(5'd10, 2'b01, 3'b010, 2'd0, 32'h0, 32'hDEAD_BEEF);
        chk("lw0", wd, 32'hDEAD_BEEF);
        chk("lw0_regwrite", 32'(regwrite), 32'h1);
        chk("lw0_misalign", 32'(load_misalign), 32'h0);
        issue(5'd10, 2'b01, 3'b010, 2'd1, 32'h0, 32'hDEAD_BEEF);
        chk("lw1_regwrite", 32'(regwrite), 32'h0);
        chk("lw1_misalign", 32'(load_misalign), 32'h1);
        issue(5'd10, 2'b01, 3'b001, 2'd1, 32'h0, 32'hDEAD_BEEF);
        chk("lh1_misalign", 32'(load_misalign), 32'h1);
        issue(5'd11, 2'b11, 3'b000, 2'd0, 32'h1234_5678, 32'hDEAD_BEEF);
        chk("sel11_wd", wd, 32'h0);
        chk("sel11_regwrite", 32'(regwrite), 32'h1);
        issue(5'd12, 2'b10, 3'b000, 2'd0, 32'h0, 32'h0);
        chk("pc4_wd", wd, 32'h0000_1004);
        tick;
        chk("load_count", retire_count, 32'd10);
        chk("x10_lw", rf[10], 32'hDEAD_BEEF);

        issue(5'd7, 2'b00, 3'b000, 2'd0, 32'hCAFE_BABE, 32'h0);
        stall = 1'b1;
        #1;
        chk("stall_hold_wd", wd, 32'hCAFE_BABE);
        for (int i = 0; i < 3; i++) begin
            chk("stall_regwrite", 32'(regwrite), 32'h0);
            tick;
        end
        chk("stall_no_write", 32'(w7), 32'd0);
        chk("stall_count", retire_count, 32'd10);
        stall = 1'b0;
        #1;
        chk("unstall_regwrite", 32'(regwrite), 32'h1);
        tick;
        chk("stall_one_write", 32'(w7), 32'd1);
        chk("stall_x7", rf[7], 32'hCAFE_BABE);
        chk("stall_count_inc", retire_count, 32'd11);

        issue(5'd8, 2'b00, 3'b000, 2'd0, 32'h1357_9BDF, 32'h0);
        stall = 1'b1; flush = 1'b1;
        tick;
        stall = 1'b0; flush = 1'b0;
        #1;
        chk("flush_regwrite", 32'(regwrite), 32'h0);
        tick;
        chk("flush_x8", rf[8], 32'h0);
        chk("flush_count", retire_count, 32'd11);

        issue(5'd0, 2'b00, 3'b000, 2'd0, 32'h5555_5555, 32'h0);
        chk("x0_regwrite", 32'(regwrite), 32'h0);
        tick;
        chk("x0_value", rf[0], 32'h0);
        chk("x0_count", retire_count, 32'd12);

        issue(5'd9, 2'b00, 3'b000, 2'd0, 32'h9999_9999, 32'h0);
        rst = 1'b1;
        tick; tick;
        chk("mid_rst_regwrite", 32'(regwrite), 32'h0);
        chk("mid_rst_rd", 32'(rd), 32'h0);
        chk("mid_rst_wd", wd, 32'h0);
        chk("mid_rst_count", retire_count, 32'h0);
        chk("mid_rst_misalign", 32'(load_misalign), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) issue(5'd3, 2'b00, 3'b000, 2'd0, 32'(i), 32'h0);
        tick;
        chk("wrap_count4", 32'(retire_count4), 32'd1);
        chk("wrap_count32", retire_count, 32'd17);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
